// File: rtl/traffic_phase_controller.sv
// N-phase signalised-junction controller: round-robin green/yellow/all-red with a
// tick-enable timebase, optional demand-actuated skipping and emergency preemption.
module traffic_phase_controller #(
  parameter  int NUM_PHASES   = 4,
  parameter  int CNT_W        = 4,
  parameter  int GREEN_TICKS  = 7,
  parameter  int YELLOW_TICKS = 2,
  parameter  int ALLRED_TICKS = 1,
  parameter  int DEMAND_MODE  = 0,
  localparam int PH_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic [NUM_PHASES-1:0]   demand,
  input  logic                    preempt,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [CNT_W-1:0]        count,
  output logic [2:0]              ps,
  output logic [PH_W-1:0]         phase
);

  typedef enum logic [2:0] {
    S_ALLRED  = 3'd0,
    S_GREEN   = 3'd1,
    S_YELLOW  = 3'd2,
    S_PREEMPT = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [3*NUM_PHASES-1:0] ALL_RED = {NUM_PHASES{3'b100}};

  state_t                  r_state;
  logic [CNT_W-1:0]        r_count;
  logic [PH_W-1:0]         r_phase;
  logic [3*NUM_PHASES-1:0] r_lights;

  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [PH_W-1:0]         w_phase_nxt;
  logic [3*NUM_PHASES-1:0] w_lights_nxt;
  logic [CNT_W-1:0]        w_dur_last;
  logic                    w_expire;
  logic                    w_found;
  logic [PH_W-1:0]         w_sel;

  // Group index p+k folded back into 0..NUM_PHASES-1 (k never exceeds NUM_PHASES).
  function automatic logic [PH_W-1:0] wrap_add(input logic [PH_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_PHASES) s = s - NUM_PHASES;
    return PH_W'(s);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_phase;
    if (DEMAND_MODE == 0) begin
      w_found = 1'b1;
      w_sel   = wrap_add(r_phase, 1);
    end else begin
      // Search starts after the last-served group; the final probe is that group itself.
      for (int i = 1; i <= NUM_PHASES; i++) begin
        if (!w_found && demand[wrap_add(r_phase, i)]) begin
          w_found = 1'b1;
          w_sel   = wrap_add(r_phase, i);
        end
      end
    end
  end

  always_comb begin
    w_dur_last = ALLRED_LAST;
    case (r_state)
      S_GREEN:  w_dur_last = GREEN_LAST;
      S_YELLOW: w_dur_last = YELLOW_LAST;
      default:  w_dur_last = ALLRED_LAST;
    endcase
    w_expire = tick_en && (r_count == w_dur_last);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    case (r_state)
      S_ALLRED: begin
        if (w_expire) begin
          if (preempt) begin
            w_state_nxt = S_PREEMPT;
            w_count_nxt = '0;
          end else if (w_found) begin
            w_state_nxt = S_GREEN;
            w_count_nxt = '0;
            w_phase_nxt = w_sel;
          end
          // No demand anywhere: count parks at its last value and re-arms every tick.
        end else if (tick_en) begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      S_GREEN: begin
        if (preempt || w_expire) begin
          w_state_nxt = S_YELLOW;
          w_count_nxt = '0;
        end else if (tick_en) begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      S_YELLOW: begin
        if (w_expire) begin
          w_state_nxt = S_ALLRED;
          w_count_nxt = '0;
        end else if (tick_en) begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      S_PREEMPT: begin
        w_count_nxt = '0;
        if (!preempt) w_state_nxt = S_ALLRED;
      end
      default: begin
        w_state_nxt = S_ALLRED;
        w_count_nxt = '0;
      end
    endcase
  end

  // Lamp pattern is derived from the next state so lights change on the same edge as ps.
  always_comb begin
    w_lights_nxt = ALL_RED;
    for (int g = 0; g < NUM_PHASES; g++) begin
      if (PH_W'(g) == w_phase_nxt) begin
        if (w_state_nxt == S_GREEN)       w_lights_nxt[3*g +: 3] = 3'b001;
        else if (w_state_nxt == S_YELLOW) w_lights_nxt[3*g +: 3] = 3'b010;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_ALLRED;
      r_count  <= '0;
      r_phase  <= PH_W'(NUM_PHASES - 1);
      r_lights <= ALL_RED;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_phase  <= w_phase_nxt;
      r_lights <= w_lights_nxt;
    end
  end

  assign ps     = r_state;
  assign count  = r_count;
  assign phase  = r_phase;
  assign lights = r_lights;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: directed stimulus pushes hand-derived
// expected states; a monitor pops one entry per clock and compares.
module tb_traffic_phase_controller;

  localparam logic [2:0] AR = 3'd0;
  localparam logic [2:0] GR = 3'd1;
  localparam logic [2:0] YE = 3'd2;
  localparam logic [2:0] PR = 3'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       preempt = 1'b0;
  logic [3:0] demand = 4'b0000;

  logic [3:0] g_dem = 4'b0000;
  logic       g_pre = 1'b0;

  logic [11:0] l_fix, l_dem;
  logic [8:0]  l_p3;
  logic [3:0]  c_fix, c_dem, c_p3;
  logic [2:0]  s_fix, s_dem, s_p3;
  logic [1:0]  p_fix, p_dem, p_p3;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .NUM_PHASES(4), .CNT_W(4), .GREEN_TICKS(7), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .DEMAND_MODE(0)
  ) u_fix (
    .clk(clk), .rst(rst), .tick_en(tick_en), .demand(demand), .preempt(preempt),
    .lights(l_fix), .count(c_fix), .ps(s_fix), .phase(p_fix)
  );

  traffic_phase_controller #(
    .NUM_PHASES(4), .CNT_W(4), .GREEN_TICKS(7), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .DEMAND_MODE(1)
  ) u_dem (
    .clk(clk), .rst(rst), .tick_en(tick_en), .demand(demand), .preempt(preempt),
    .lights(l_dem), .count(c_dem), .ps(s_dem), .phase(p_dem)
  );

  traffic_phase_controller #(
    .NUM_PHASES(3), .CNT_W(4), .GREEN_TICKS(5), .YELLOW_TICKS(1), .ALLRED_TICKS(2), .DEMAND_MODE(0)
  ) u_p3 (
    .clk(clk), .rst(rst), .tick_en(tick_en), .demand(demand[2:0]), .preempt(preempt),
    .lights(l_p3), .count(c_p3), .ps(s_p3), .phase(p_p3)
  );

  typedef struct {
    string      tag;
    int         id;
    logic [2:0] ps;
    logic [3:0] cnt;
    logic [2:0] ph;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [23:0] exp_lights(int n, logic [2:0] eps, logic [2:0] eph);
    logic [23:0] l;
    logic [2:0]  grp;
    l = '0;
    for (int g = 0; g < n; g++) begin
      grp = 3'b100;
      if (g == int'(eph) && eps == GR) grp = 3'b001;
      if (g == int'(eph) && eps == YE) grp = 3'b010;
      l = l | (24'(grp) << (3 * g));
    end
    return l;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive inputs away from the active edge, queue the result expected after it.
  task automatic step(int id, bit r, bit t, logic [2:0] eps, logic [3:0] ecnt, logic [2:0] eph,
                      string tag);
    exp_t e;
    @(negedge clk);
    rst     = r;
    tick_en = t;
    demand  = g_dem;
    preempt = g_pre;
    e.tag = tag; e.id = id; e.ps = eps; e.cnt = ecnt; e.ph = eph;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // A state value held for p clocks: one ticking edge enters it, p-1 idle edges hold it.
  task automatic show(int id, logic [2:0] eps, logic [3:0] ecnt, logic [2:0] eph, int p, string tag);
    step(id, 1'b0, 1'b1, eps, ecnt, eph, tag);
    for (int k = 1; k < p; k++) step(id, 1'b0, 1'b0, eps, ecnt, eph, tag);
  endtask

  task automatic do_reset(int id, int ph_rst, string tag);
    for (int k = 0; k < 2; k++) step(id, 1'b1, 1'b1, AR, 4'd0, 3'(ph_rst), tag);
  endtask

  task automatic group(int id, int ph, int g, int y, int a, int p, string tag);
    for (int c = 0; c < g; c++) show(id, GR, 4'(c), 3'(ph), p, tag);
    for (int c = 0; c < y; c++) show(id, YE, 4'(c), 3'(ph), p, tag);
    for (int c = 0; c < a; c++) show(id, AR, 4'(c), 3'(ph), p, tag);
  endtask

  exp_t        m_e;
  logic [2:0]  m_ps;
  logic [3:0]  m_cnt;
  logic [2:0]  m_ph;
  logic [23:0] m_l;
  int          m_n;
  int          m_nonred;

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      case (m_e.id)
        0:       begin m_ps = s_fix; m_cnt = c_fix; m_ph = {1'b0, p_fix}; m_l = {12'b0, l_fix}; m_n = 4; end
        1:       begin m_ps = s_dem; m_cnt = c_dem; m_ph = {1'b0, p_dem}; m_l = {12'b0, l_dem}; m_n = 4; end
        default: begin m_ps = s_p3;  m_cnt = c_p3;  m_ph = {1'b0, p_p3};  m_l = {15'b0, l_p3};  m_n = 3; end
      endcase
      check({m_e.tag, " ps/count/phase"}, 64'({m_ps, m_cnt, m_ph}), 64'({m_e.ps, m_e.cnt, m_e.ph}));
      check({m_e.tag, " lights"}, 64'(m_l), 64'(exp_lights(m_n, m_e.ps, m_e.ph)));
      m_nonred = 0;
      for (int g = 0; g < m_n; g++) if (m_l[3*g +: 3] != 3'b100) m_nonred++;
      n_checks++;
      if (m_nonred > 1) begin
        n_errors++;
        $display("FAIL %s one-non-red: got %0d non-red groups expected at most 1", m_e.tag, m_nonred);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Fixed-time sequence: five groups covers the 40-clock period and the 3->0 wrap.
    g_dem = 4'b0000; g_pre = 1'b0;
    do_reset(0, 3, "t1_reset");
    for (int k = 0; k < 5; k++) group(0, k % 4, 7, 2, 1, 1, "t1_fixed");

    // Tick gating: one tick in four stretches every state by 4x.
    do_reset(0, 3, "t2_reset");
    group(0, 0, 7, 2, 1, 4, "t2_gated");
    group(0, 1, 7, 2, 1, 4, "t2_gated");

    // Preemption from green count 3 of group 1.
    do_reset(0, 3, "t4_reset");
    group(0, 0, 7, 2, 1, 1, "t4_pre");
    for (int c = 0; c < 4; c++) show(0, GR, 4'(c), 3'd1, 1, "t4_pre");
    g_pre = 1'b1;
    show(0, YE, 4'd0, 3'd1, 1, "t4_pre_yel");
    show(0, YE, 4'd1, 3'd1, 1, "t4_pre_yel");
    show(0, AR, 4'd0, 3'd1, 1, "t4_pre_ar");
    for (int k = 0; k < 3; k++) show(0, PR, 4'd0, 3'd1, 1, "t4_preempt");
    for (int k = 0; k < 2; k++) step(0, 1'b0, 1'b0, PR, 4'd0, 3'd1, "t4_preempt_notick");
    g_pre = 1'b0;
    show(0, AR, 4'd0, 3'd1, 1, "t4_release");
    group(0, 2, 7, 2, 1, 1, "t4_resume");
    show(0, GR, 4'd0, 3'd3, 1, "t4_pre2");
    show(0, GR, 4'd1, 3'd3, 1, "t4_pre2");
    g_pre = 1'b1;
    step(0, 1'b0, 1'b0, YE, 4'd0, 3'd3, "t4_pre_green_notick");
    show(0, YE, 4'd1, 3'd3, 1, "t4_pre2_yel");
    show(0, AR, 4'd0, 3'd3, 1, "t4_pre2_ar");
    show(0, PR, 4'd0, 3'd3, 1, "t4_pre2_hold");
    g_pre = 1'b0;
    show(0, AR, 4'd0, 3'd3, 1, "t4_pre2_release");
    show(0, GR, 4'd0, 3'd0, 1, "t4_pre2_wrap");

    // Reset while yellow count is 1.
    do_reset(0, 3, "t5_reset");
    for (int c = 0; c < 7; c++) show(0, GR, 4'(c), 3'd0, 1, "t5_run");
    show(0, YE, 4'd0, 3'd0, 1, "t5_run");
    show(0, YE, 4'd1, 3'd0, 1, "t5_run");
    step(0, 1'b1, 1'b1, AR, 4'd0, 3'd3, "t5_mid_reset");
    group(0, 0, 7, 2, 1, 1, "t5_restart");

    // Demand-actuated skipping.
    g_dem = 4'b1010;
    do_reset(1, 3, "t3_reset");
    group(1, 1, 7, 2, 1, 1, "t3_skip");
    group(1, 3, 7, 2, 1, 1, "t3_skip");
    group(1, 1, 7, 2, 1, 1, "t3_skip");
    group(1, 3, 7, 2, 1, 1, "t3_skip");
    g_dem = 4'b0000;
    for (int k = 0; k < 3; k++) show(1, AR, 4'd0, 3'd3, 1, "t3_no_demand");
    g_dem = 4'b0100;
    group(1, 2, 7, 2, 1, 1, "t3_raise2");
    group(1, 2, 7, 2, 1, 1, "t3_self_again");

    // Three-phase parametrisation: 24-clock period, 2->0 wrap.
    g_dem = 4'b0000;
    do_reset(2, 2, "t6_reset");
    show(2, AR, 4'd1, 3'd2, 1, "t6_first_allred");
    for (int k = 0; k < 4; k++) group(2, k % 3, 5, 1, 2, 1, "t6_p3");

    @(posedge clk);
    #3;
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Parametrised N-phase signalised-junction controller. Next generation of the fixed four-road controller.
- Cycles through NUM_PHASES signal groups: one group green at a time, then yellow, then an all-red clearance.
- Adds configurable durations, a tick-enable timebase, optional demand-actuated phase skipping, and emergency preemption.
- Sits directly below the junction top level; lamp drivers consume the flattened lights bus.

Parameters:
- NUM_PHASES, 4, number of signal groups (2..8)
- CNT_W, 4, width of the count output/timer
- GREEN_TICKS, 7, green duration in ticks (1..2^CNT_W)
- YELLOW_TICKS, 2, yellow duration in ticks (1..2^CNT_W)
- ALLRED_TICKS, 1, all-red clearance in ticks (1..2^CNT_W)
- DEMAND_MODE, 0, 0 = fixed-time (ignore demand), 1 = skip groups without demand

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- tick_en  input  1  timebase strobe; timer advances only when high
- demand  input  NUM_PHASES  per-group request, level, sampled when a group is selected
- preempt  input  1  emergency preemption request, level
- lights  output  3*NUM_PHASES  group g at [3g+2:3g], one-hot {red,yellow,green}: 100 red, 010 yellow, 001 green
- count  output  CNT_W  ticks elapsed in current state
- ps  output  3  present state
- phase  output  clog2(NUM_PHASES) (min 1)  index of current/last-served group

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Outputs: all outputs are registered and update on the same edge as the state.
- States (ps encoding): ALLRED=0, GREEN=1, YELLOW=2, PREEMPT=3. Codes 4..7 are illegal and recover to ALLRED with count=0 on the next edge.
- Reset: rst high at an edge forces ps=ALLRED, count=0, phase=NUM_PHASES-1, all lights 100.
  - rst overrides tick_en, preempt and demand.
  - rst is honoured in any state, including mid-yellow.
- Timer:
  - "Expire" means tick_en=1 and count == DUR-1 for the current state's duration.
  - On expire: transition and set count=0.
  - Otherwise, if tick_en=1: count+1.
  - If tick_en=0: count and state hold, except the preemption cases below.
- ALLRED:
  - All groups 100.
  - On expire with preempt=1: go to PREEMPT.
  - On expire, otherwise: select the next group by round-robin search from phase+1, wrapping at NUM_PHASES-1 to 0.
    - DEMAND_MODE=0: next = phase+1 mod N.
    - DEMAND_MODE=1: next = first index in search order with demand=1, which may be phase itself.
  - If a group is selected: phase←next, go to GREEN.
  - DEMAND_MODE=1 with demand all zero: stay in ALLRED, count holds at ALLRED_TICKS-1, re-evaluate on every tick.
- GREEN:
  - lights[phase]=001, all others 100.
  - On expire: go to YELLOW.
  - preempt=1: go to YELLOW with count=0 on the next edge, regardless of tick_en.
- YELLOW:
  - lights[phase]=010, all others 100.
  - On expire: go to ALLRED.
  - preempt does not shorten yellow.
- PREEMPT:
  - All groups 100; count held at 0.
  - Stay while preempt=1.
  - On the first edge with preempt=0: go to ALLRED, count=0.
  - phase is unchanged, so round-robin resumes after the interrupted group.
- Simultaneous events:
  - preempt arriving on a green-expire edge gives YELLOW (same result).
  - Demand changes outside the ALLRED selection edge have no effect.
- Invariant: at most one group is non-red in any cycle. Never green→red directly except via reset.

Test Plan:
1. Fixed-time sequence (defaults, tick_en=1): rst 2 cycles then 0.
   - Expect ps=0, lights=12'h924 (all 100), phase=3 during reset.
   - First edge after reset: phase=0, lights[2:0]=001.
   - Group 0 green 7 cycles, yellow 2, all-red 1; group 1 green starts 10 cycles after group 0.
   - Cycle repeats every 40 cycles.
2. Tick gating: tick_en high 1 cycle in 4 → every state duration ×4 (green 28 clocks). count increments only on tick cycles.
3. Demand skip (DEMAND_MODE=1): demand=4'b1010 → greens alternate phase 1, 3, 1, 3; groups 0 and 2 stay 100 throughout.
   - demand=0 → remains ALLRED, count=0.
   - Raising demand[2] → GREEN for phase 2 on the next tick.
4. Preemption: assert preempt at green count=3 of phase 1.
   - Next edge: YELLOW, count=0. Then 2 yellow, 1 all-red, then PREEMPT (ps=3, all 100) while preempt held.
   - Drop preempt → ALLRED 1 tick, then phase 2 green.
5. Reset mid-operation: rst=1 during YELLOW count=1 → next edge ps=0, count=0, phase=3, all red. The sequence restarts at phase 0.
6. Parametrisation: NUM_PHASES=3, GREEN_TICKS=5, YELLOW_TICKS=1, ALLRED_TICKS=2.
   - 9-bit lights; phase wraps 2→0; period 24 cycles.
   - Invariant check: never more than one non-red group.
